// File: rtl/conv1d_pkg.sv
// Shared constants for the conv1d requantisation stage: parameter-select
// encodings, int32 limits, default activation clamp and pipeline depth.
package conv1d_pkg;

  // param_sel encodings
  localparam logic [2:0] SEL_BIAS    = 3'd0;
  localparam logic [2:0] SEL_MULT    = 3'd1;
  localparam logic [2:0] SEL_SHIFT   = 3'd2;
  localparam logic [2:0] SEL_OFFSET  = 3'd3;
  localparam logic [2:0] SEL_ACT_MIN = 3'd4;
  localparam logic [2:0] SEL_ACT_MAX = 3'd5;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

  localparam logic signed [31:0] ACT_MIN_DEFAULT = -32'sd128;
  localparam logic signed [31:0] ACT_MAX_DEFAULT = 32'sd127;

  localparam int unsigned NUM_STAGES = 4;

endpackage

// File: rtl/conv1d_requant_srdhm.sv
// Saturating rounding doubling high multiply (TFLite SRDHM) back end:
// turns the 64-bit product into the rounded high word, or INT32_MAX when
// the single overflowing operand pair was detected upstream.
module requant_srdhm
  import conv1d_pkg::*;
(
  input  logic signed [63:0] p,
  input  logic               sat,
  output logic signed [31:0] y
);

  logic signed [63:0] nudged;
  logic signed [63:0] q;

  // Nudge toward the rounding point, then divide by 2^31 truncating toward zero
  always_comb begin
    nudged = p + ((p >= 0) ? 64'sd1073741824 : -64'sd1073741823);
    if (nudged < 0) q = (nudged + 64'sd2147483647) >>> 31;
    else            q = nudged >>> 31;
    y = sat ? INT32_MAX : 32'(q);
  end

endmodule

// File: rtl/conv1d_requant.sv
// conv1d_requant: bias add, fixed-point rescale, output offset and clamp of
// int32 convolution accumulators into int8 activations; 4-stage pipeline
// with a single global advance.
// Build option: REQUANT_PER_CHANNEL_EN selects per-channel multiplier/shift
// memories; without it they are single global registers (reset to 0).
module conv1d_requant
  import conv1d_pkg::*;
#(
  parameter int INT32_SIZE          = 32,
  parameter int BYTE_SIZE           = 8,
  parameter int MAX_OUTPUT_CHANNELS = 128,
  parameter int CH_W                = $clog2(MAX_OUTPUT_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         param_we,
  input  logic [2:0]                   param_sel,
  input  logic [CH_W-1:0]              param_addr,
  input  logic signed [INT32_SIZE-1:0] param_wdata,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [INT32_SIZE-1:0] in_acc,
  input  logic [CH_W-1:0]              in_channel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [BYTE_SIZE-1:0]  out_data,
  output logic                         busy
);

  logic                  adv;
  logic [NUM_STAGES-1:0] vld;

  // Parameter storage
  logic signed [INT32_SIZE-1:0] bias_mem [MAX_OUTPUT_CHANNELS];
  logic signed [INT32_SIZE-1:0] output_offset, act_min, act_max;
`ifdef REQUANT_PER_CHANNEL_EN
  logic signed [INT32_SIZE-1:0] mult_mem  [MAX_OUTPUT_CHANNELS];
  logic signed [5:0]            shift_mem [MAX_OUTPUT_CHANNELS];
`else
  logic signed [INT32_SIZE-1:0] mult_reg;
  logic signed [5:0]            shift_reg;
`endif

  // Stage 1: accumulator plus registered parameter reads
  logic signed [INT32_SIZE-1:0] acc1, bias1, mult1;
  logic signed [5:0]            shift1;
  // Stage 2 combinational and registered
  logic signed [INT32_SIZE-1:0] x2, xl2;
  logic [4:0]                   left2, right2c;
  logic signed [63:0]           prod2c;
  logic                         sat2c;
  logic signed [63:0]           prod2;
  logic                         sat2;
  logic [4:0]                   right2;
  // Stage 3
  logic signed [INT32_SIZE-1:0] y3c, y3;
  logic [4:0]                   right3;
  // Stage 4 combinational
  logic [INT32_SIZE-1:0]        mask4, rem4, thr4;
  logic signed [INT32_SIZE-1:0] z4, sum4, res4;
  logic signed [BYTE_SIZE-1:0]  out_next;

  assign adv       = !vld[NUM_STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[NUM_STAGES-1];
  assign busy      = |vld;

  // Per-channel memory writes (never cleared by reset, never blocked)
  always_ff @(posedge clk) begin
    if (param_we && param_sel == SEL_BIAS)  bias_mem[param_addr]  <= param_wdata;
`ifdef REQUANT_PER_CHANNEL_EN
    if (param_we && param_sel == SEL_MULT)  mult_mem[param_addr]  <= param_wdata;
    if (param_we && param_sel == SEL_SHIFT) shift_mem[param_addr] <= 6'(param_wdata);
`endif
  end

  // Global parameter registers with reset defaults
  always_ff @(posedge clk) begin
    if (reset) begin
      output_offset <= '0;
      act_min       <= ACT_MIN_DEFAULT;
      act_max       <= ACT_MAX_DEFAULT;
`ifndef REQUANT_PER_CHANNEL_EN
      mult_reg      <= '0;
      shift_reg     <= '0;
`endif
    end else if (param_we) begin
      case (param_sel)
        SEL_OFFSET:  output_offset <= param_wdata;
        SEL_ACT_MIN: act_min       <= param_wdata;
        SEL_ACT_MAX: act_max       <= param_wdata;
`ifndef REQUANT_PER_CHANNEL_EN
        SEL_MULT:    mult_reg      <= param_wdata;
        SEL_SHIFT:   shift_reg     <= 6'(param_wdata);
`endif
        default: ;
      endcase
    end
  end

  // Stage-valid shift register; a bubble only moves when the pipe advances
  always_ff @(posedge clk) begin
    if (reset)    vld <= '0;
    else if (adv) vld <= {vld[NUM_STAGES-2:0], in_valid};
  end

  // Stage 1: registered RAM reads at the accepting edge (read-before-write,
  // so a same-cycle parameter write is not seen); the bias add is moved to
  // the next stage so the memories keep a plain registered read port
  always_ff @(posedge clk) begin
    if (adv) begin
      acc1  <= in_acc;
      bias1 <= bias_mem[in_channel];
`ifdef REQUANT_PER_CHANNEL_EN
      mult1  <= mult_mem[in_channel];
      shift1 <= shift_mem[in_channel];
`else
      mult1  <= mult_reg;
      shift1 <= shift_reg;
`endif
    end
  end

  // Stage 2: bias add, left shift, full-width product, saturation detect
  always_comb begin
    x2 = acc1 + bias1;
    if (shift1 > 0) begin
      left2   = 5'(shift1);
      right2c = '0;
    end else begin
      left2   = '0;
      right2c = 5'(-shift1);
    end
    xl2    = x2 << left2;
    prod2c = 64'(xl2) * 64'(mult1);
    sat2c  = (xl2 == INT32_MIN) && (mult1 == INT32_MIN);
  end

  // Stage 2 register
  always_ff @(posedge clk) begin
    if (adv) begin
      prod2  <= prod2c;
      sat2   <= sat2c;
      right2 <= right2c;
    end
  end

  requant_srdhm u_srdhm (
    .p   (prod2),
    .sat (sat2),
    .y   (y3c)
  );

  // Stage 3 register
  always_ff @(posedge clk) begin
    if (adv) begin
      y3     <= y3c;
      right3 <= right2;
    end
  end

  // Stage 4: rounding right shift, output offset, activation clamp
  always_comb begin
    mask4 = (32'd1 << right3) - 32'd1;
    rem4  = y3 & mask4;
    thr4  = (mask4 >> 1) + {31'd0, y3[31]};
    z4    = (y3 >>> right3) + ((rem4 > thr4) ? 32'sd1 : 32'sd0);
    sum4  = z4 + output_offset;
    if (sum4 < act_min)      res4 = act_min;
    else if (sum4 > act_max) res4 = act_max;
    else                     res4 = sum4;
    out_next = BYTE_SIZE'(res4);
  end

  // Output register; holds its value while stalled or empty
  always_ff @(posedge clk) begin
    if (reset)                          out_data <= '0;
    else if (adv && vld[NUM_STAGES-2])  out_data <= out_next;
  end

endmodule

// File: tb/tb_conv1d_requant.sv
// Directed self-checking bench for conv1d_requant.
module tb_conv1d_requant;
  import conv1d_pkg::*;

  localparam int CH_W = 7;
  localparam logic signed [31:0] Q30 = 32'sh4000_0000;
  localparam logic signed [31:0] Q29 = 32'sh2000_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              param_we = 1'b0;
  logic [2:0]        param_sel = '0;
  logic [CH_W-1:0]   param_addr = '0;
  logic signed [31:0] param_wdata = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [31:0] in_acc = '0;
  logic [CH_W-1:0]   in_channel = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_data;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  conv1d_requant dut (
    .clk         (clk),
    .reset       (reset),
    .param_we    (param_we),
    .param_sel   (param_sel),
    .param_addr  (param_addr),
    .param_wdata (param_wdata),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_acc      (in_acc),
    .in_channel  (in_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_param(input logic [2:0] sel, input logic [CH_W-1:0] addr,
                             input logic signed [31:0] data);
    @(negedge clk);
    param_we = 1'b1; param_sel = sel; param_addr = addr; param_wdata = data;
    @(negedge clk);
    param_we = 1'b0;
  endtask

  // Single transfer into an idle pipe; returns result and cycles to out_valid
  task automatic push_and_wait(input logic signed [31:0] acc, input logic [CH_W-1:0] ch,
                               output logic signed [7:0] data, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_acc = acc; in_channel = ch; out_ready = 1'b1;
    @(posedge clk);
    lat = -1;
    data = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = c;
        data = out_data;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    tests_run++; if (out_data !== 8'sd0) begin tests_failed++; $display("FAIL reset_out_data: got %0d need 0", out_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b need 0", busy); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_basic;
    logic signed [7:0] d; int lat;
    write_param(SEL_BIAS, 7'd0, 32'sd0);
    write_param(SEL_MULT, 7'd0, Q30);
    write_param(SEL_SHIFT, 7'd0, 32'sd0);
    write_param(SEL_OFFSET, 7'd0, -32'sd128);
    push_and_wait(32'sd100, 7'd0, d, lat);
    tests_run++; if (d !== -8'sd78) begin tests_failed++; $display("FAIL basic_data: got %0d need -78", d); end
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL basic_latency: got %0d need 4", lat); end
  endtask

  task automatic test_saturation;
    logic signed [7:0] d; int lat;
    write_param(SEL_OFFSET, 7'd0, 32'sd0);
    push_and_wait(-32'sd3, 7'd0, d, lat);
    tests_run++; if (d !== -8'sd1) begin tests_failed++; $display("FAIL neg_small: got %0d need -1 (lat %0d)", d, lat); end
    write_param(SEL_MULT, 7'd0, INT32_MIN);
    push_and_wait(INT32_MIN, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd127) begin tests_failed++; $display("FAIL srdhm_sat: got %0d need 127 (lat %0d)", d, lat); end
    write_param(SEL_MULT, 7'd0, Q30);
  endtask

  task automatic test_rounding;
    logic signed [7:0] d; int lat;
    write_param(SEL_OFFSET, 7'd0, 32'sd0);
    write_param(SEL_SHIFT, 7'd0, -32'sd2);
    push_and_wait(32'sd1000, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd125) begin tests_failed++; $display("FAIL round_1000: got %0d need 125", d); end
    push_and_wait(32'sd1002, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd125) begin tests_failed++; $display("FAIL round_1002: got %0d need 125", d); end
    push_and_wait(32'sd1006, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd126) begin tests_failed++; $display("FAIL round_1006: got %0d need 126", d); end
    push_and_wait(-32'sd1006, 7'd0, d, lat);
    tests_run++; if (d !== -8'sd126) begin tests_failed++; $display("FAIL round_m1006: got %0d need -126", d); end
    write_param(SEL_SHIFT, 7'd0, 32'sd1);
    push_and_wait(32'sd100, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd100) begin tests_failed++; $display("FAIL left_shift: got %0d need 100", d); end
    write_param(SEL_SHIFT, 7'd0, 32'sd0);
  endtask

  task automatic test_clamp;
    logic signed [7:0] d; int lat;
    write_param(SEL_ACT_MIN, 7'd0, -32'sd10);
    write_param(SEL_ACT_MAX, 7'd0, 32'sd10);
    push_and_wait(32'sd100, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd10) begin tests_failed++; $display("FAIL clamp_hi: got %0d need 10", d); end
    push_and_wait(-32'sd100, 7'd0, d, lat);
    tests_run++; if (d !== -8'sd10) begin tests_failed++; $display("FAIL clamp_lo: got %0d need -10", d); end
    push_and_wait(32'sd20, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd10) begin tests_failed++; $display("FAIL clamp_edge: got %0d need 10", d); end
    push_and_wait(32'sd18, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd9) begin tests_failed++; $display("FAIL clamp_inside: got %0d need 9", d); end
    write_param(SEL_ACT_MIN, 7'd0, -32'sd128);
    write_param(SEL_ACT_MAX, 7'd0, 32'sd127);
  endtask

  task automatic test_per_channel;
    logic signed [7:0] d; int lat;
    write_param(SEL_BIAS, 7'd3, 32'sd24);
    write_param(SEL_MULT, 7'd3, Q30);
    write_param(SEL_SHIFT, 7'd3, 32'sd0);
    write_param(SEL_OFFSET, 7'd0, -32'sd500);
    push_and_wait(32'sd1000, 7'd3, d, lat);
    tests_run++; if (d !== 8'sd12) begin tests_failed++; $display("FAIL bias_ch3: got %0d need 12", d); end
    push_and_wait(32'sd1000, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd0) begin tests_failed++; $display("FAIL bias_ch0: got %0d need 0", d); end
    write_param(SEL_OFFSET, 7'd0, 32'sd0);
`ifdef REQUANT_PER_CHANNEL_EN
    write_param(SEL_BIAS, 7'd5, 32'sd0);
    write_param(SEL_SHIFT, 7'd5, 32'sd0);
    write_param(SEL_MULT, 7'd5, Q29);
    push_and_wait(32'sd200, 7'd5, d, lat);
    tests_run++; if (d !== 8'sd50) begin tests_failed++; $display("FAIL mult_ch5: got %0d need 50", d); end
    push_and_wait(32'sd200, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd100) begin tests_failed++; $display("FAIL mult_ch0: got %0d need 100", d); end
`else
    write_param(SEL_MULT, 7'd5, Q29);
    push_and_wait(32'sd200, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd50) begin tests_failed++; $display("FAIL mult_global: got %0d need 50", d); end
`endif
    write_param(SEL_MULT, 7'd0, Q30);
  endtask

  task automatic test_param_timing;
    logic signed [7:0] got [2];
    int n;
    @(negedge clk);
    param_we = 1'b1; param_sel = SEL_BIAS; param_addr = 7'd0; param_wdata = 32'sd40;
    in_valid = 1'b1; in_acc = 32'sd100; in_channel = 7'd0; out_ready = 1'b1;
    @(negedge clk);
    param_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    got[0] = '0; got[1] = '0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && n < 2) begin got[n] = out_data; n++; end
      @(negedge clk);
    end
    tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL timing_count: got %0d need 2", n); end
    tests_run++; if (got[0] !== 8'sd50) begin tests_failed++; $display("FAIL timing_old_bias: got %0d need 50", got[0]); end
    tests_run++; if (got[1] !== 8'sd70) begin tests_failed++; $display("FAIL timing_new_bias: got %0d need 70", got[1]); end
    write_param(SEL_BIAS, 7'd0, 32'sd0);
  endtask

  task automatic test_back_to_back;
    int sent, recv, extra;
    logic signed [7:0] prev, expv;
    logic prev_stalled;
    sent = 0; recv = 0; prev = '0; prev_stalled = 1'b0;
    write_param(SEL_OFFSET, 7'd0, 32'sd0);
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      out_ready  = !(cyc >= 6 && cyc < 11);
      in_valid   = (sent < 8);
      in_acc     = 20 * sent + 2;
      in_channel = 7'd0;
      #1;
      if (prev_stalled) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== prev) begin
          tests_failed++;
          $display("FAIL stall_hold: got valid %b data %0d need valid 1 data %0d", out_valid, out_data, prev);
        end
      end
      if (out_valid && !out_ready) begin
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready: got %b need 0", in_ready); end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        expv = 8'(10 * recv + 1);
        tests_run++;
        if (out_data !== expv) begin tests_failed++; $display("FAIL stream_%0d: got %0d need %0d", recv, out_data, expv); end
        recv++;
      end
      prev_stalled = out_valid && !out_ready;
      prev = out_data;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    tests_run++; if (sent !== 8) begin tests_failed++; $display("FAIL stream_sent: got %0d need 8", sent); end
    tests_run++; if (recv !== 8) begin tests_failed++; $display("FAIL stream_recv: got %0d need 8", recv); end
    tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL stream_extra: got %0d need 0", extra); end
  endtask

  task automatic test_reset_midstream;
    logic signed [7:0] d; int lat, seen;
    write_param(SEL_ACT_MIN, 7'd0, -32'sd10);
    write_param(SEL_ACT_MAX, 7'd0, 32'sd10);
    write_param(SEL_OFFSET, 7'd0, 32'sd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_acc = 32'sd100; in_channel = 7'd0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL inflight_busy: got %b need 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b need 0", busy); end
    tests_run++; if (out_data !== 8'sd0) begin tests_failed++; $display("FAIL midreset_data: got %0d need 0", out_data); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL midreset_no_output: got %0d valid cycles need 0", seen); end
    write_param(SEL_MULT, 7'd0, Q30);
    write_param(SEL_SHIFT, 7'd0, 32'sd0);
    write_param(SEL_MULT, 7'd3, Q30);
    write_param(SEL_SHIFT, 7'd3, 32'sd0);
    push_and_wait(-32'sd24, 7'd3, d, lat);
    tests_run++; if (d !== 8'sd0) begin tests_failed++; $display("FAIL retained_bias: got %0d need 0", d); end
    push_and_wait(32'sd200, 7'd3, d, lat);
    tests_run++; if (d !== 8'sd112) begin tests_failed++; $display("FAIL default_range: got %0d need 112", d); end
    push_and_wait(32'sd300, 7'd0, d, lat);
    tests_run++; if (d !== 8'sd127) begin tests_failed++; $display("FAIL default_max: got %0d need 127", d); end
    push_and_wait(-32'sd300, 7'd0, d, lat);
    tests_run++; if (d !== -8'sd128) begin tests_failed++; $display("FAIL default_min: got %0d need -128", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_clamp();
    test_per_channel();
    test_param_timing();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
